// File: rtl/ssm_tile_feeder.sv
// ssm_tile_feeder: fetches a group's B/C/hprev tiles from fixed-latency tile memory and
// streams them downstream with the group scalars held, through a credit-managed return FIFO.
//
// state | meaning
// IDLE  | waiting for a group descriptor
// ISSUE | issuing tile reads whenever FIFO credit allows
// DRAIN | all reads issued, waiting for the last beat to leave
module ssm_tile_feeder #(
  parameter int DW      = 16,
  parameter int H_TILE  = 1,
  parameter int P_TILE  = 1,
  parameter int N_TILE  = 128,
  parameter int N_TOTAL = 128,
  parameter int RD_LAT  = 2,
  parameter int ADDR_W  = 16
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic                                grp_valid_i,
  output logic                                grp_ready_o,
  input  logic [ADDR_W-1:0]                   grp_idx_i,
  input  logic [H_TILE*DW-1:0]                dt_i,
  input  logic [H_TILE*DW-1:0]                dt_bias_i,
  input  logic [H_TILE*DW-1:0]                A_i,
  input  logic [H_TILE*DW-1:0]                D_i,
  input  logic [H_TILE*P_TILE*DW-1:0]         x_i,
  output logic                                rd_en_o,
  output logic [ADDR_W-1:0]                   rd_addr_o,
  input  logic [N_TILE*DW-1:0]                rd_B_i,
  input  logic [N_TILE*DW-1:0]                rd_C_i,
  input  logic [H_TILE*P_TILE*N_TILE*DW-1:0]  rd_hprev_i,
  output logic                                tile_valid_o,
  input  logic                                tile_ready_i,
  output logic                                tile_last_o,
  output logic [H_TILE*DW-1:0]                dt_o,
  output logic [H_TILE*DW-1:0]                dt_bias_o,
  output logic [H_TILE*DW-1:0]                A_o,
  output logic [H_TILE*DW-1:0]                D_o,
  output logic [H_TILE*P_TILE*DW-1:0]         x_o,
  output logic [N_TILE*DW-1:0]                B_tile_o,
  output logic [N_TILE*DW-1:0]                C_tile_o,
  output logic [H_TILE*P_TILE*N_TILE*DW-1:0]  hprev_tile_o,
  output logic                                busy_o,
  output logic                                group_done_o
);

  localparam int TILES = (N_TOTAL + N_TILE - 1) / N_TILE;
  localparam int DEPTH = RD_LAT + 2;
  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int NW    = $clog2(TILES + 1);
  localparam int TW    = N_TILE * DW;
  localparam int HW    = H_TILE * P_TILE * N_TILE * DW;
  localparam logic [ADDR_W-1:0] TILES_A = ADDR_W'(TILES);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

  state_t              state;
  logic                ready_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [NW-1:0]       left_q;
  logic [RD_LAT-1:0]   vld_sr;
  logic [RD_LAT-1:0]   lst_sr;
  logic [TW-1:0]       b_mem [DEPTH];
  logic [TW-1:0]       c_mem [DEPTH];
  logic [HW-1:0]       h_mem [DEPTH];
  logic [DEPTH-1:0]    l_mem;
  logic [PW-1:0]       wr_ptr;
  logic [PW-1:0]       rd_ptr;
  logic [CW-1:0]       fifo_cnt;
  logic [CW-1:0]       inflight;
  logic [CW:0]         used;
  logic                accept;
  logic                issue;
  logic                push;
  logic                fire;
  logic                head_vld;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + CW'(vld_sr[i]);
  end

  // Credit counts both buffered entries and reads still in the memory pipe.
  assign used     = {1'b0, fifo_cnt} + {1'b0, inflight};
  assign issue    = (state == S_ISSUE) && (used < (CW+1)'(DEPTH));
  assign accept   = (state == S_IDLE) && ready_q && grp_valid_i;
  assign push     = vld_sr[RD_LAT-1];
  assign head_vld = (fifo_cnt != '0);
  assign fire     = head_vld && tile_ready_i;

  assign grp_ready_o  = ready_q;
  assign busy_o       = (state != S_IDLE);
  assign rd_en_o      = issue;
  assign rd_addr_o    = issue ? addr_q : '0;
  assign tile_valid_o = head_vld;
  assign tile_last_o  = head_vld && l_mem[rd_ptr];
  assign group_done_o = fire && tile_last_o;
  assign B_tile_o     = head_vld ? b_mem[rd_ptr] : '0;
  assign C_tile_o     = head_vld ? c_mem[rd_ptr] : '0;
  assign hprev_tile_o = head_vld ? h_mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= S_IDLE;
      ready_q   <= 1'b0;
      addr_q    <= '0;
      left_q    <= '0;
      dt_o      <= '0;
      dt_bias_o <= '0;
      A_o       <= '0;
      D_o       <= '0;
      x_o       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          ready_q <= !accept;
          if (accept) begin
            dt_o      <= dt_i;
            dt_bias_o <= dt_bias_i;
            A_o       <= A_i;
            D_o       <= D_i;
            x_o       <= x_i;
            addr_q    <= grp_idx_i * TILES_A;
            left_q    <= NW'(TILES);
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (issue) begin
            addr_q <= addr_q + 1'b1;
            left_q <= left_q - 1'b1;
            if (left_q == NW'(1)) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (group_done_o) begin
            state   <= S_IDLE;
            ready_q <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Read-return tracker and FIFO bookkeeping; reset drops anything still in flight.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      vld_sr   <= '0;
      lst_sr   <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      vld_sr[0] <= issue;
      lst_sr[0] <= issue && (left_q == NW'(1));
      for (int i = 1; i < RD_LAT; i++) begin
        vld_sr[i] <= vld_sr[i-1];
        lst_sr[i] <= lst_sr[i-1];
      end
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (fire) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, fire})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      b_mem[wr_ptr] <= rd_B_i;
      c_mem[wr_ptr] <= rd_C_i;
      h_mem[wr_ptr] <= rd_hprev_i;
      l_mem[wr_ptr] <= lst_sr[RD_LAT-1];
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rstn)
    !(push && !fire && (fifo_cnt == CW'(DEPTH))));

endmodule

// File: tb/tb_ssm_tile_feeder.sv
// Bench for ssm_tile_feeder: queue-based reference model checked every cycle,
// directed group scenarios with literal timing/data expectations, then random traffic.
module tb_ssm_tile_feeder;
  localparam int DW = 16, H_TILE = 1, P_TILE = 1, N_TILE = 32, N_TOTAL = 100;
  localparam int RD_LAT = 2, ADDR_W = 16;
  localparam int TILES = (N_TOTAL + N_TILE - 1) / N_TILE;
  localparam int DEPTH = RD_LAT + 2;
  localparam int TW = N_TILE * DW;
  localparam int HW = H_TILE * P_TILE * N_TILE * DW;

  logic clk = 0, rstn = 0;
  logic grp_valid_i = 0, grp_ready_o;
  logic [ADDR_W-1:0] grp_idx_i = '0;
  logic [15:0] dt_i = '0, dt_bias_i = '0, A_i = '0, D_i = '0, x_i = '0;
  logic rd_en_o;
  logic [ADDR_W-1:0] rd_addr_o;
  logic [TW-1:0] rd_B_i, rd_C_i;
  logic [HW-1:0] rd_hprev_i;
  logic tile_valid_o, tile_ready_i = 1, tile_last_o;
  logic [15:0] dt_o, dt_bias_o, A_o, D_o, x_o;
  logic [TW-1:0] B_tile_o, C_tile_o;
  logic [HW-1:0] hprev_tile_o;
  logic busy_o, group_done_o;

  ssm_tile_feeder #(.DW(DW), .H_TILE(H_TILE), .P_TILE(P_TILE), .N_TILE(N_TILE),
                    .N_TOTAL(N_TOTAL), .RD_LAT(RD_LAT), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rstn(rstn), .grp_valid_i(grp_valid_i), .grp_ready_o(grp_ready_o),
    .grp_idx_i(grp_idx_i), .dt_i(dt_i), .dt_bias_i(dt_bias_i), .A_i(A_i), .D_i(D_i),
    .x_i(x_i), .rd_en_o(rd_en_o), .rd_addr_o(rd_addr_o), .rd_B_i(rd_B_i),
    .rd_C_i(rd_C_i), .rd_hprev_i(rd_hprev_i), .tile_valid_o(tile_valid_o),
    .tile_ready_i(tile_ready_i), .tile_last_o(tile_last_o), .dt_o(dt_o),
    .dt_bias_o(dt_bias_o), .A_o(A_o), .D_o(D_o), .x_o(x_o), .B_tile_o(B_tile_o),
    .C_tile_o(C_tile_o), .hprev_tile_o(hprev_tile_o), .busy_o(busy_o),
    .group_done_o(group_done_o));

  always #5 clk = ~clk;

  // Tile memory: element i of a tile at address a is (a*0x0101 ^ salt) + i.
  function automatic logic [TW-1:0] pat(input logic [15:0] a, input logic [15:0] salt);
    logic [TW-1:0] r;
    logic [15:0] b;
    b = a * 16'h0101;
    for (int i = 0; i < N_TILE; i++) r[i*16 +: 16] = (b ^ salt) + 16'(i);
    return r;
  endfunction

  logic [RD_LAT-1:0] mv;
  logic [15:0] ma [RD_LAT];
  always @(posedge clk) begin
    mv[0] <= rd_en_o;
    ma[0] <= rd_addr_o;
    for (int i = 1; i < RD_LAT; i++) begin
      mv[i] <= mv[i-1];
      ma[i] <= ma[i-1];
    end
  end
  assign rd_B_i     = mv[RD_LAT-1] ? pat(ma[RD_LAT-1], 16'h0000) : {N_TILE{16'hdead}};
  assign rd_C_i     = mv[RD_LAT-1] ? pat(ma[RD_LAT-1], 16'hffff) : {N_TILE{16'hdead}};
  assign rd_hprev_i = mv[RD_LAT-1] ? pat(ma[RD_LAT-1], 16'h5a5a) : {N_TILE{16'hdead}};

  int n_chk = 0, n_err = 0, cyc = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic chk_w(input string nm, input logic [HW-1:0] act, input logic [HW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got_lo=%h exp_lo=%h", nm, cyc, act[31:0], exp[31:0]);
    end
  endtask

  // Reference model: a group is a list of tile reads; returns land in a queue of beats.
  typedef struct { int t; logic [15:0] addr; int cyc; } ent_t;
  ent_t infl[$];
  ent_t fq[$];
  bit m_active = 0, m_ready = 0;
  int m_left = 0, m_next_t = 0;
  logic [15:0] m_base = '0, m_dt = '0, m_dtb = '0, m_a = '0, m_d = '0, m_x = '0;

  int lg_acc, lg_done;
  int lg_rd_cyc[$], lg_beat_cyc[$];
  logic [15:0] lg_rd_addr[$], lg_beat_b[$];

  task automatic clear_logs();
    lg_acc = -1; lg_done = -1;
    lg_rd_cyc.delete(); lg_beat_cyc.delete(); lg_rd_addr.delete(); lg_beat_b.delete();
  endtask

  function automatic int qi(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -999;
  endfunction

  function automatic int qa(input logic [15:0] q[$], input int i);
    return (i < q.size()) ? int'(q[i]) : -999;
  endfunction

  // Inputs for the current cycle are already driven; check, log, advance model, move on.
  task automatic step();
    bit e_valid, e_last, e_fire, e_done, e_rd;
    logic [15:0] e_addr;
    ent_t e;
    #1;
    e_valid = fq.size() > 0;
    e_last = 0;
    if (e_valid) e_last = (fq[0].t == TILES - 1);
    e_fire = e_valid && tile_ready_i;
    e_done = e_fire && e_last;
    e_rd = m_active && (m_left > 0) && (fq.size() + infl.size() < DEPTH);
    e_addr = m_base + 16'(m_next_t);
    chk("grp_ready", grp_ready_o, m_ready);
    chk("busy", busy_o, m_active);
    chk("rd_en", rd_en_o, e_rd);
    if (e_rd) chk("rd_addr", rd_addr_o, e_addr);
    chk("tile_valid", tile_valid_o, e_valid);
    chk("tile_last", tile_last_o, e_last);
    chk("group_done", group_done_o, e_done);
    if (e_valid) begin
      chk_w("B_tile", B_tile_o, pat(fq[0].addr, 16'h0000));
      chk_w("C_tile", C_tile_o, pat(fq[0].addr, 16'hffff));
      chk_w("hprev_tile", hprev_tile_o, pat(fq[0].addr, 16'h5a5a));
    end
    chk("dt", dt_o, m_dt);
    chk("dt_bias", dt_bias_o, m_dtb);
    chk("A", A_o, m_a);
    chk("D", D_o, m_d);
    chk("x", x_o, m_x);
    if (rd_en_o) begin lg_rd_cyc.push_back(cyc); lg_rd_addr.push_back(rd_addr_o); end
    if (tile_valid_o && tile_ready_i) begin
      lg_beat_cyc.push_back(cyc); lg_beat_b.push_back(B_tile_o[15:0]);
    end
    if (group_done_o) lg_done = cyc;
    if (grp_valid_i && grp_ready_o) lg_acc = cyc;
    if (!rstn) begin
      infl.delete(); fq.delete();
      m_active = 0; m_ready = 0; m_left = 0; m_next_t = 0; m_base = '0;
      m_dt = '0; m_dtb = '0; m_a = '0; m_d = '0; m_x = '0;
    end else begin
      if (e_fire) void'(fq.pop_front());
      while (infl.size() > 0 && infl[0].cyc <= cyc - RD_LAT) begin
        e = infl.pop_front();
        fq.push_back(e);
      end
      if (e_rd) begin
        e.t = m_next_t; e.addr = e_addr; e.cyc = cyc;
        infl.push_back(e);
        m_next_t++; m_left--;
      end
      if (e_done) m_active = 0;
      if (grp_valid_i && m_ready) begin
        m_active = 1; m_base = grp_idx_i * 16'(TILES); m_left = TILES; m_next_t = 0;
        m_dt = dt_i; m_dtb = dt_bias_i; m_a = A_i; m_d = D_i; m_x = x_i;
      end
      m_ready = !m_active;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_group(input logic [15:0] idx, input int s_from, input int s_to,
                           input bit hold, output int t0, output int rc);
    int k;
    clear_logs();
    grp_valid_i = 1; grp_idx_i = idx; tile_ready_i = 1;
    dt_i = 16'h1000 + idx; dt_bias_i = 16'h2000 + idx; A_i = 16'h3000 + idx;
    D_i = 16'h4000 + idx; x_i = 16'h5000 + idx;
    step();
    t0 = lg_acc;
    grp_valid_i = hold;
    if (hold) begin
      grp_idx_i = 16'h0bad; dt_i = 16'hbeef; dt_bias_i = 16'hbeef;
      A_i = 16'hbeef; D_i = 16'hbeef; x_i = 16'hbeef;
    end
    k = 0;
    while (!grp_ready_o && k < 60) begin
      tile_ready_i = !((cyc - t0) >= s_from && (cyc - t0) <= s_to);
      step();
      k++;
    end
    chk("group_end_ready", grp_ready_o, 1);
    rc = cyc;
    grp_valid_i = 0;
    tile_ready_i = 1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, rc, k;
    clear_logs();
    rstn = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ready", grp_ready_o, 0);
    chk("reset_valid", tile_valid_o, 0);
    rstn = 1;
    step();
    chk("ready_after_release", grp_ready_o, 1);

    // Group 0, no backpressure.
    run_group(16'd0, -1, -1, 0, t0, rc);
    for (int i = 0; i < 4; i++) begin
      chk("t1_rd_cyc", qi(lg_rd_cyc, i) - t0, 1 + i);
      chk("t1_rd_addr", qa(lg_rd_addr, i), i);
      chk("t1_beat_cyc", qi(lg_beat_cyc, i) - t0, 4 + i);
    end
    chk("t1_done", lg_done - t0, 7);
    chk("t1_ready", rc - t0, 8);

    // Same group with downstream stalled for cycles 4..13.
    run_group(16'd0, 4, 13, 0, t0, rc);
    for (int i = 0; i < 4; i++) begin
      chk("t2_rd_cyc", qi(lg_rd_cyc, i) - t0, 1 + i);
      chk("t2_beat_cyc", qi(lg_beat_cyc, i) - t0, 14 + i);
      chk("t2_beat_data", qa(lg_beat_b, i), i * 16'h0101);
    end
    chk("t2_done", lg_done - t0, 17);

    // Group 5 addresses and data.
    run_group(16'd5, -1, -1, 0, t0, rc);
    for (int i = 0; i < 4; i++) begin
      chk("t3_rd_addr", qa(lg_rd_addr, i), 20 + i);
      chk("t3_beat_data", qa(lg_beat_b, i), (20 + i) * 16'h0101);
    end
    chk("t3_first_b", qa(lg_beat_b, 0), 16'h1414);

    // Descriptor held while busy must be ignored.
    run_group(16'd2, -1, -1, 1, t0, rc);
    chk("t4_dt_held", dt_o, 16'h1002);
    chk("t4_A_held", A_o, 16'h3002);
    chk("t4_x_held", x_o, 16'h5002);
    chk("t4_rd_count", lg_rd_cyc.size(), 4);

    // Reset right after the second beat.
    clear_logs();
    grp_valid_i = 1; grp_idx_i = 16'd3;
    step();
    grp_valid_i = 0;
    k = 0;
    while (lg_beat_cyc.size() < 2 && k < 20) begin step(); k++; end
    chk("t5_two_beats", lg_beat_cyc.size(), 2);
    rstn = 0;
    step();
    rstn = 1;
    chk("t5_valid_after_rst", tile_valid_o, 0);
    chk("t5_busy_after_rst", busy_o, 0);
    chk("t5_ready_in_rst", grp_ready_o, 0);
    chk("t5_dt_cleared", dt_o, 0);
    step();
    chk("t5_ready_release", grp_ready_o, 1);
    run_group(16'd7, -1, -1, 0, t0, rc);
    for (int i = 0; i < 4; i++) begin
      chk("t5_rd_addr", qa(lg_rd_addr, i), 28 + i);
      chk("t5_beat_cyc", qi(lg_beat_cyc, i) - t0, 4 + i);
      chk("t5_beat_data", qa(lg_beat_b, i), (28 + i) * 16'h0101);
    end

    // Random traffic: descriptors, backpressure, wrapping indices, rare resets.
    for (int n = 0; n < 3000; n++) begin
      rstn = ($urandom_range(0, 249) != 0);
      grp_valid_i = ($urandom_range(0, 3) == 0);
      grp_idx_i = 16'($urandom);
      dt_i = 16'($urandom); dt_bias_i = 16'($urandom); A_i = 16'($urandom);
      D_i = 16'($urandom); x_i = 16'($urandom);
      tile_ready_i = ($urandom_range(0, 9) < 7);
      step();
    end
    rstn = 1; grp_valid_i = 0; tile_ready_i = 1;
    repeat (20) step();
    chk("final_idle", grp_ready_o, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
